mem_access_ctrl: RTL and testbench

- Multicycle load/store sequencer between the main control FSM and the single word-wide unified memory.
- Converts word, halfword and byte loads/stores (LW, LHU, LBU, SW, SH, SB) into aligned 32-bit memory transactions.
- Performs zero-extension on loads and read-modify-write on sub-word stores.
- Flags misaligned or illegal accesses so control can trap (EPC/rte path).

---
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Control-side request/response and memory-side bus of the load/store sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface mem_access_ctrl_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        error;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic [1:0]  state_out;

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output rdata, done, error, busy, mem_addr, mem_wdata, mem_wr, state_out
    );

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  rdata, done, error, busy, mem_addr, mem_wdata, mem_wr, state_out
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: turns LW/LHU/LBU/SW/SH/SB into aligned word
// accesses, zero-extending loads and doing read-modify-write for sub-word stores.
module mem_access_ctrl #(
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);
    localparam logic [2:0] OP_SB = 3'b101;
    localparam logic [2:0] OP_SH = 3'b110;
    localparam logic [2:0] OP_SW = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        error_q, error_d;

    logic        bad_req;
    logic [31:0] shifted;
    logic [31:0] load_word;
    logic [31:0] merged_word;

    // Illegal encodings plus word/half accesses not aligned to their size.
    assign bad_req = (bus.op[1:0] == 2'b11)
                  || (bus.op[1:0] == 2'b00 && bus.addr[1:0] != 2'b00)
                  || (bus.op[1:0] == 2'b10 && bus.addr[0]);

    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_word = bus.mem_rdata;
        case (op_q[1:0])
            2'b01:   load_word = {24'b0, shifted[7:0]};
            2'b10:   load_word = {16'b0, shifted[15:0]};
            default: load_word = bus.mem_rdata;
        endcase
    end

    // Each byte lane keeps the sampled memory byte unless the store targets it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;
            assign lane_hit = (op_q == OP_SB && off_q == 2'(gi))
                           || (op_q == OP_SH && off_q[1] == 1'(gi / 2));
            assign lane_src = (op_q == OP_SB) ? wdata_q[7:0] : wdata_q[8*(gi%2) +: 8];
            assign merged_word[8*gi +: 8] = lane_hit ? lane_src : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    op_d       = bus.op;
                    off_d      = bus.addr[1:0];
                    wdata_d    = bus.wdata[15:0];
                    mem_addr_d = {bus.addr[31:2], 2'b00};
                    if (bad_req) begin
                        error_d = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b0;
                        if (bus.op == OP_SW) begin
                            mem_wdata_d = bus.wdata;
                            state_d     = S_WRITE;
                        end else begin
                            cnt_d   = 2'(READ_LAT - 1);
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                if (cnt_q == 2'd0) begin
                    if (op_q[2]) begin
                        mem_wdata_d = merged_word;
                        state_d     = S_WRITE;
                    end else begin
                        rdata_d = load_word;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            error_q     <= error_d;
        end
    end

    // Status decoded straight from the state register so reset removes mem_wr at once.
    assign bus.rdata     = rdata_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.error     = (state_q == S_DONE) && error_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_wr    = (state_q == S_WRITE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (READ_LAT 1 and 3) share the same
// request stream; each has its own latency-aware memory, checked against a word model.
module tb_mem_access_ctrl;
    localparam int          RL1     = 1;
    localparam int          RL3     = 3;
    localparam logic [31:0] GARBAGE = 32'hBAD0_0BAD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if b1 ();
    mem_access_ctrl_if b3 ();

    mem_access_ctrl #(.READ_LAT(RL1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_access_ctrl #(.READ_LAT(RL3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    assign b3.req   = b1.req;
    assign b3.op    = b1.op;
    assign b3.addr  = b1.addr;
    assign b3.wdata = b1.wdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pmem1 [256];
    logic [31:0] pmem3 [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last1, last3;
    int          age1, age3, wr1, wr3;
    int          stable1, stable3;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            8:       return 32'h11223344;
            default: return 32'(i) * 32'h9E3779B1 + 32'h1234;
        endcase
    endfunction

    // Data is only valid once mem_addr has been stable long enough for the latency.
    assign stable1 = (b1.mem_addr == last1) ? age1 + 1 : 0;
    assign stable3 = (b3.mem_addr == last3) ? age3 + 1 : 0;
    assign b1.mem_rdata = (stable1 >= RL1 - 1) ? pmem1[b1.mem_addr[9:2]] : GARBAGE;
    assign b3.mem_rdata = (stable3 >= RL3 - 1) ? pmem3[b3.mem_addr[9:2]] : GARBAGE;

    initial begin
        for (int i = 0; i < 256; i++) pmem1[i] = init_word(i);
        last1 = '0; age1 = 0; wr1 = 0;
        forever begin
            @(posedge clk);
            age1  <= (b1.mem_addr == last1) ? ((age1 < 1000) ? age1 + 1 : age1) : 0;
            last1 <= b1.mem_addr;
            if (b1.mem_wr) begin
                pmem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
                wr1 <= wr1 + 1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) pmem3[i] = init_word(i);
        last3 = '0; age3 = 0; wr3 = 0;
        forever begin
            @(posedge clk);
            age3  <= (b3.mem_addr == last3) ? ((age3 < 1000) ? age3 + 1 : age3) : 0;
            last3 <= b3.mem_addr;
            if (b3.mem_wr) begin
                pmem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
                wr3 <= wr3 + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int n = 0; n < 40 && (b1.busy || b3.busy); n++) @(negedge clk);
        check("idle_wait", {30'b0, b1.busy, b3.busy}, 32'h0);
    endtask

    function automatic logic [31:0] exp_state(input int c, input int rl);
        int p;
        p = c % (rl + 2);
        return (p < rl) ? 32'd1 : ((p == rl) ? 32'd3 : 32'd0);
    endfunction

    // Model works on whole words: size/offset arithmetic with masks and shifts.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input string tag, output logic o_err, output logic [31:0] o_rd,
                           output int o_lat);
        int          size, shift, lat1, lat3, x1, x3, w1, w3;
        longint      mask;
        logic        err, store, e1, e3;
        logic [31:0] word, exp_rd, exp_word, ma1, ma3, r1, r3;
        size  = (op[1:0] == 2'b00) ? 4 : ((op[1:0] == 2'b01) ? 1 : 2);
        err   = (op[1:0] == 2'b11) || ((int'(addr[1:0]) % size) != 0);
        store = op[2];
        word  = ref_mem[addr[9:2]];
        shift = int'(addr[1:0]) * 8;
        mask  = (longint'(1) << (8 * size)) - 1;
        exp_rd   = err ? 32'h0 : 32'((longint'(word) >> shift) & mask);
        exp_word = (store && !err)
                 ? 32'((longint'(word) & ~(mask << shift)) | ((longint'(wdata) & mask) << shift))
                 : word;
        x1 = err ? 0 : (store ? ((size == 4) ? 1 : RL1 + 1) : RL1);
        x3 = err ? 0 : (store ? ((size == 4) ? 1 : RL3 + 1) : RL3);
        w1 = wr1;
        w3 = wr3;
        wait_idle();
        b1.req = 1'b1; b1.op = op; b1.addr = addr; b1.wdata = wdata;
        @(posedge clk); #1;
        ma1 = b1.mem_addr;
        ma3 = b3.mem_addr;
        b1.req = 1'b0; b1.op = 3'($urandom); b1.addr = $urandom; b1.wdata = $urandom;
        lat1 = -1; lat3 = -1; e1 = 1'b0; e3 = 1'b0; r1 = '0; r3 = '0;
        for (int n = 0; n < 24; n++) begin
            if (lat1 < 0 && b1.done) begin lat1 = n; e1 = b1.error; r1 = b1.rdata; end
            if (lat3 < 0 && b3.done) begin lat3 = n; e3 = b3.error; r3 = b3.rdata; end
            if (lat1 >= 0 && lat3 >= 0) break;
            @(posedge clk); #1;
        end
        check({tag, ".lat1"}, 32'(lat1), 32'(x1));
        check({tag, ".lat3"}, 32'(lat3), 32'(x3));
        check({tag, ".err1"}, {31'b0, e1}, {31'b0, err});
        check({tag, ".err3"}, {31'b0, e3}, {31'b0, err});
        check({tag, ".maddr1"}, ma1, {addr[31:2], 2'b00});
        check({tag, ".maddr3"}, ma3, {addr[31:2], 2'b00});
        check({tag, ".writes1"}, 32'(wr1 - w1), (store && !err) ? 32'd1 : 32'd0);
        check({tag, ".writes3"}, 32'(wr3 - w3), (store && !err) ? 32'd1 : 32'd0);
        if (!store || err) begin
            check({tag, ".rdata1"}, r1, exp_rd);
            check({tag, ".rdata3"}, r3, exp_rd);
        end
        check({tag, ".mem1"}, pmem1[addr[9:2]], exp_word);
        check({tag, ".mem3"}, pmem3[addr[9:2]], exp_word);
        ref_mem[addr[9:2]] = exp_word;
        $display("%s op=%b addr=%08h wdata=%08h -> err=%0d rdata=%08h lat=%0d/%0d",
                 tag, op, addr, wdata, e1, r1, lat1, lat3);
        o_err = e1;
        o_rd  = r1;
        o_lat = lat1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic        e;
        logic [31:0] r;
        int          l, w1;
        logic [2:0]  rop;
        logic [31:0] raddr;

        vecs[0]  = '{3'b000, 32'h10, 32'h0,         1'b0, 32'hDEADBEEF, 1, 32'h0};
        vecs[1]  = '{3'b001, 32'h13, 32'h0,         1'b0, 32'h000000DE, 1, 32'h0};
        vecs[2]  = '{3'b010, 32'h12, 32'h0,         1'b0, 32'h0000DEAD, 1, 32'h0};
        vecs[3]  = '{3'b001, 32'h10, 32'h0,         1'b0, 32'h000000EF, 1, 32'h0};
        vecs[4]  = '{3'b101, 32'h21, 32'hFFFFFFAA,  1'b0, 32'h0,        2, 32'h1122AA44};
        vecs[5]  = '{3'b110, 32'h13, 32'h0,         1'b1, 32'h0,        0, 32'h0};
        vecs[6]  = '{3'b011, 32'h00, 32'h0,         1'b1, 32'h0,        0, 32'h0};
        vecs[7]  = '{3'b100, 32'h24, 32'hCAFEF00D,  1'b0, 32'h0,        1, 32'hCAFEF00D};
        vecs[8]  = '{3'b010, 32'h22, 32'h0,         1'b0, 32'h00001122, 1, 32'h0};
        vecs[9]  = '{3'b000, 32'h11, 32'h0,         1'b1, 32'h0,        0, 32'h0};
        vecs[10] = '{3'b110, 32'h26, 32'h12345678,  1'b0, 32'h0,        2, 32'h5678F00D};
        vecs[11] = '{3'b111, 32'h08, 32'h0,         1'b1, 32'h0,        0, 32'h0};

        b1.req = 1'b0; b1.op = '0; b1.addr = '0; b1.wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        #2 rst = 1'b1;
        #2;
        check("reset.state",     {30'b0, b1.state_out}, 32'h0);
        check("reset.rdata",     b1.rdata, 32'h0);
        check("reset.mem_addr",  b1.mem_addr, 32'h0);
        check("reset.mem_wdata", b1.mem_wdata, 32'h0);
        check("reset.flags",     {28'b0, b1.done, b1.error, b1.busy, b1.mem_wr}, 32'h0);
        check("reset.state3",    {30'b0, b3.state_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), e, r, l);
            check($sformatf("vec%0d.tbl_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d.tbl_lat", i), 32'(l), 32'(vecs[i].exp_lat));
            if (!vecs[i].op[2] || vecs[i].exp_err)
                check($sformatf("vec%0d.tbl_rdata", i), r, vecs[i].exp_rdata);
            if (vecs[i].op[2] && !vecs[i].exp_err)
                check($sformatf("vec%0d.tbl_word", i), pmem1[vecs[i].addr[9:2]], vecs[i].exp_word);
        end

        // Reset while the RL=1 instance is in the write cycle of an SB.
        wait_idle();
        w1 = wr1;
        b1.req = 1'b1; b1.op = 3'b101; b1.addr = 32'h21; b1.wdata = 32'h55;
        @(posedge clk); #1 b1.req = 1'b0;
        @(posedge clk); #1;
        check("rstwr.mem_wr_before", {31'b0, b1.mem_wr}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rstwr.mem_wr_now", {31'b0, b1.mem_wr}, 32'h0);
        check("rstwr.state_now",  {30'b0, b1.state_out}, 32'h0);
        check("rstwr.busy_now",   {31'b0, b1.busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstwr.no_done", {31'b0, b1.done}, 32'h0);
        check("rstwr.no_write", 32'(wr1 - w1), 32'h0);
        check("rstwr.mem_kept", pmem1[8], ref_mem[8]);
        $display("rst_mid_write SB addr=00000021 -> writes=%0d word=%08h", wr1 - w1, pmem1[8]);
        run_txn(3'b000, 32'h10, 32'h0, "after_rst", e, r, l);
        check("after_rst.rdata", r, 32'hDEADBEEF);

        // req held high: accept happens only from IDLE, never in DONE.
        wait_idle();
        b1.req = 1'b1; b1.op = 3'b000; b1.addr = 32'h10; b1.wdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("held.state1_c%0d", c), {30'b0, b1.state_out}, exp_state(c, RL1));
            check($sformatf("held.state3_c%0d", c), {30'b0, b3.state_out}, exp_state(c, RL3));
        end
        b1.req = 1'b0;
        $display("held_req LW addr=00000010 -> 10 cycles of state sequence compared");

        for (int t = 0; t < 150; t++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = $urandom;
            if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
            run_txn(rop, raddr, $urandom, $sformatf("rnd%0d", t), e, r, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
